fir_hs_ctrl: RTL

//  Handshake sequencer for the 3-way polyphase FIR: forks one 4-phase input handshake to the

---
 rtl/fir_hs_ctrl_pkg.sv | 28 ++
 rtl/fir_hs_ctrl_hs_join.sv | 45 ++++
 rtl/fir_hs_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_hs_ctrl_pkg.sv
// Shared definitions for the polyphase FIR handshake sequencer:
// FSM state encodings, error bit indices and the debug view of both FSMs.
package fir_hs_ctrl_pkg;

    // Input FSM states
    localparam logic [1:0] IN_IDLE  = 2'd0;
    localparam logic [1:0] IN_FORK  = 2'd1;
    localparam logic [1:0] IN_ACK   = 2'd2;
    localparam logic [1:0] IN_REL   = 2'd3;

    // Output FSM states (2'd3 unused, recovers to OUT_IDLE)
    localparam logic [1:0] OUT_IDLE = 2'd0;
    localparam logic [1:0] OUT_CAPT = 2'd1;
    localparam logic [1:0] OUT_ACK  = 2'd2;

    // Sticky error bit positions
    localparam int ERR_W      = 3;
    localparam int ERR_IN_TO  = 0;
    localparam int ERR_OUT_TO = 1;
    localparam int ERR_SPUR   = 2;

    // Debug view of both FSMs, exported on the top-level port o_dbg
    typedef struct packed {
        logic [1:0] in_state;
        logic [1:0] out_state;
    } fsm_dbg_t;

endpackage

// File: rtl/fir_hs_ctrl_hs_join.sv
// Join detector for NR_SUB handshake wires: reports all-high / all-low and
// raises a one-cycle timeout pulse when a partial join (some but not all
// wires high) persists for TIMEOUT enabled cycles. The counter saturates so
// the pulse fires once per stall; a full or empty join re-arms it.
module hs_join #(
    parameter int NR_SUB  = 3,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [NR_SUB-1:0] i_bits,
    output logic              o_all_hi,
    output logic              o_all_lo,
    output logic              o_timeout
);

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;
    logic            w_partial;

    assign o_all_hi  = &i_bits;
    assign o_all_lo  = ~|i_bits;
    assign w_partial = ~o_all_hi & ~o_all_lo;

    // Pulse on the cycle the partial-join count reaches TIMEOUT
    assign o_timeout = i_en & w_partial & (r_cnt == TO_LAST);

    // Count enabled partial-join cycles, saturating at TIMEOUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_en && w_partial) begin
            if (r_cnt != TO_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/fir_hs_ctrl.sv
// Handshake sequencer for the 3-way polyphase FIR. Forks the input 4-phase
// handshake to the subfilter lanes, joins their acks, joins the subfilter
// results into the output handshake, and strobes the merged-output register.
//
// Handshake protocol (all ports): 4-phase return-to-zero. A requester raises
// req and holds it until it sees ack high; it then drops req and may not raise
// it again until ack has returned low. The acknowledger raises ack only in
// response to req, holds it until req falls, then drops it. Data crossing the
// handshake is valid from ack rising until req falls.
module fir_hs_ctrl
    import fir_hs_ctrl_pkg::*;
#(
    parameter int NR_SUB       = 3,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3,
    parameter int TIMEOUT      = 64,
    parameter int TO_W         = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    output logic              ack_in,
    input  logic              req_out,
    output logic              ack_out,
    output logic [NR_SUB-1:0] sf_req_in,
    input  logic [NR_SUB-1:0] sf_ack_in,
    input  logic [NR_SUB-1:0] sf_req_out,
    output logic [NR_SUB-1:0] sf_ack_out,
    output logic              cap_en,
    output logic [CNT_W-1:0]  inflight,
    output logic [ERR_W-1:0]  err,
    input  logic              err_clr,
    output fsm_dbg_t          o_dbg
);

    localparam logic [CNT_W-1:0] INFLIGHT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [1:0]        r_in_state;
    logic [1:0]        r_out_state;
    logic              r_ack_in;
    logic              r_ack_out;
    logic [NR_SUB-1:0] r_sf_req_in;
    logic [NR_SUB-1:0] r_sf_ack_out;
    logic              r_cap_en;
    logic [CNT_W-1:0]  r_inflight;
    logic [ERR_W-1:0]  r_err;

    logic              w_ack_all_hi;
    logic              w_ack_all_lo;
    logic              w_in_to;
    logic              w_oreq_all_hi;
    logic              w_oreq_all_lo;
    logic              w_out_to;
    logic              w_in_join_en;
    logic              w_out_join_en;
    logic              w_accept;
    logic              w_deliver;
    logic              w_capture;
    logic              w_spurious;
    logic [ERR_W-1:0]  w_err_set;

    // Input join: lane acks are watched while the fork is pending or releasing
    assign w_in_join_en = (r_in_state == IN_FORK) | (r_in_state == IN_REL);

    hs_join #(
        .NR_SUB  (NR_SUB),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_join_in (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_in_join_en),
        .i_bits    (sf_ack_in),
        .o_all_hi  (w_ack_all_hi),
        .o_all_lo  (w_ack_all_lo),
        .o_timeout (w_in_to)
    );

    // Output join: lane results are watched only while waiting to capture
    assign w_out_join_en = (r_out_state == OUT_IDLE);

    hs_join #(
        .NR_SUB  (NR_SUB),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_join_out (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_out_join_en),
        .i_bits    (sf_req_out),
        .o_all_hi  (w_oreq_all_hi),
        .o_all_lo  (w_oreq_all_lo),
        .o_timeout (w_out_to)
    );

    // Acceptance: all lanes have taken the sample. Delivery: capture cycle.
    assign w_accept   = (r_in_state == IN_FORK) & w_ack_all_hi;
    assign w_deliver  = (r_out_state == OUT_CAPT);
    assign w_capture  = (r_out_state == OUT_IDLE) & w_oreq_all_hi & req_out
                        & (r_inflight != '0);
    // A lane presenting a result with nothing in flight is a protocol error
    assign w_spurious = (r_out_state == OUT_IDLE) & ~w_oreq_all_lo
                        & (r_inflight == '0);

    always_comb begin
        w_err_set             = '0;
        w_err_set[ERR_IN_TO]  = w_in_to;
        w_err_set[ERR_OUT_TO] = w_out_to;
        w_err_set[ERR_SPUR]   = w_spurious;
    end

    // Input FSM: fork req_in to all lanes, join acks, then release in order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_state  <= IN_IDLE;
            r_sf_req_in <= '0;
            r_ack_in    <= 1'b0;
        end else begin
            case (r_in_state)
                IN_IDLE: begin
                    if (req_in && (r_inflight < INFLIGHT_MAX)) begin
                        r_in_state  <= IN_FORK;
                        r_sf_req_in <= '1;
                    end
                end
                IN_FORK: begin
                    if (w_ack_all_hi) begin
                        r_in_state <= IN_ACK;
                        r_ack_in   <= 1'b1;
                    end
                end
                IN_ACK: begin
                    if (!req_in) begin
                        r_in_state  <= IN_REL;
                        r_sf_req_in <= '0;
                    end
                end
                IN_REL: begin
                    if (w_ack_all_lo) begin
                        r_in_state <= IN_IDLE;
                        r_ack_in   <= 1'b0;
                    end
                end
                default: begin
                    r_in_state  <= IN_IDLE;
                    r_sf_req_in <= '0;
                    r_ack_in    <= 1'b0;
                end
            endcase
        end
    end

    // Output FSM: capture joined result, then hold ack until both sides release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_state  <= OUT_IDLE;
            r_cap_en     <= 1'b0;
            r_ack_out    <= 1'b0;
            r_sf_ack_out <= '0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (w_capture) begin
                        r_out_state <= OUT_CAPT;
                        r_cap_en    <= 1'b1;
                    end
                end
                OUT_CAPT: begin
                    r_out_state  <= OUT_ACK;
                    r_cap_en     <= 1'b0;
                    r_ack_out    <= 1'b1;
                    r_sf_ack_out <= '1;
                end
                OUT_ACK: begin
                    if (!req_out && w_oreq_all_lo) begin
                        r_out_state  <= OUT_IDLE;
                        r_ack_out    <= 1'b0;
                        r_sf_ack_out <= '0;
                    end
                end
                default: begin
                    r_out_state  <= OUT_IDLE;
                    r_cap_en     <= 1'b0;
                    r_ack_out    <= 1'b0;
                    r_sf_ack_out <= '0;
                end
            endcase
        end
    end

    // In-flight count: accept and deliver in the same cycle cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_deliver})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Sticky error flags; a new set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            r_err <= w_err_set | (r_err & ~{ERR_W{err_clr}});
        end
    end

    assign ack_in          = r_ack_in;
    assign ack_out         = r_ack_out;
    assign sf_req_in       = r_sf_req_in;
    assign sf_ack_out      = r_sf_ack_out;
    assign cap_en          = r_cap_en;
    assign inflight        = r_inflight;
    assign err             = r_err;
    assign o_dbg.in_state  = r_in_state;
    assign o_dbg.out_state = r_out_state;

endmodule
